psram_arbiter: RTL and testbench



---
 rtl/psram_pkg.sv | 33 +++
 rtl/psram_arbiter_rr.sv | 34 +++
 rtl/psram_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_psram_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared constants for the PSRAM subsystem: address/count widths, page geometry,
// controller opcodes and the arbiter state encoding.
package psram_pkg;

  localparam int ADDR_W      = 23;
  localparam int COUNT_W     = 9;
  localparam int PAGE_BYTES  = 1024;
  localparam int PAGE_BITS   = 10;
  localparam int PAGE_LEFT_W = PAGE_BITS + 1;

  localparam logic [7:0] CMD_READ       = 8'h03;
  localparam logic [7:0] CMD_WRITE      = 8'h02;
  localparam logic [7:0] CMD_QUAD_READ  = 8'hEB;
  localparam logic [7:0] CMD_QUAD_WRITE = 8'h38;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_XFER  = 2'd2;
  localparam state_t ST_GAP   = 2'd3;

  // Bytes that can go out before the burst would cross into the next page.
  function automatic logic [COUNT_W-1:0] chunkLen(input logic [PAGE_BITS-1:0] pageOffset,
                                                  input logic [COUNT_W-1:0]   remaining);
    logic [PAGE_LEFT_W-1:0] pageLeft;
    pageLeft = PAGE_LEFT_W'(PAGE_BYTES) - {1'b0, pageOffset};
    if ({{(PAGE_LEFT_W-COUNT_W){1'b0}}, remaining} < pageLeft)
      return remaining;
    else
      return pageLeft[COUNT_W-1:0];
  endfunction

endpackage

// File: rtl/psram_arbiter_rr.sv
// Combinational round-robin picker: one-hot grant to the first active request
// found when scanning upward from the pointer, wrapping at NREQ.
module rr_arbiter
  import psram_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         grant_o,
  output logic [$clog2(NREQ)-1:0] grantIdx_o
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant_o    = '0;
    grantIdx_o = '0;
    found      = 1'b0;
    idx        = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr_i) + i) % NREQ);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        grantIdx_o   = idx;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// Round-robin front end for the single psram_controller byte port: accepts one
// burst at a time, splits it at 1 KiB page boundaries and steers the data strobes.
module psram_arbiter
  import psram_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_write,
  input  logic [NREQ*ADDR_W-1:0]    req_addr,
  input  logic [NREQ*COUNT_W-1:0]   req_len,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           req_done,
  output logic [7:0]                rd_data,
  output logic [NREQ-1:0]           rd_valid,
  input  logic [NREQ*8-1:0]         wr_data,
  output logic [NREQ-1:0]           wr_ready,
  output logic                      mem_start_read,
  output logic                      mem_start_write,
  output logic [COUNT_W-1:0]        mem_count,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [7:0]                mem_dout,
  input  logic                      mem_r_valid,
  output logic [7:0]                mem_din,
  input  logic                      mem_w_ready,
  output logic                      stray_err
);

  localparam int OW = $clog2(NREQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t               state_q, state_d;
  logic                 write_q, write_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [COUNT_W-1:0]   remaining_q, remaining_d;
  logic [COUNT_W-1:0]   beatCnt_q, beatCnt_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        rrPtr_q, rrPtr_d;
  logic [GW-1:0]        gapCnt_q, gapCnt_d;
  logic [NREQ-1:0]      done_q, done_d;
  logic                 stray_q, stray_d;

  logic [NREQ-1:0]      grant;
  logic [OW-1:0]        grantIdx;
  logic [COUNT_W-1:0]   chunk;
  logic [COUNT_W-1:0]   remAfter;
  logic [COUNT_W-1:0]   reqLen;
  logic [NREQ-1:0]      ownerHot;
  logic                 inXfer;
  logic                 beat;
  logic                 lastBeat;

  function automatic logic [OW-1:0] nextPtr(input logic [OW-1:0] p);
    return (p == OW'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr (
    .req_i     (req_valid),
    .ptr_i     (rrPtr_q),
    .grant_o   (grant),
    .grantIdx_o(grantIdx)
  );

  assign chunk    = chunkLen(addr_q[PAGE_BITS-1:0], remaining_q);
  assign remAfter = remaining_q - chunk;
  assign reqLen   = req_len[grantIdx*COUNT_W +: COUNT_W];
  assign ownerHot = NREQ'(1) << owner_q;
  assign inXfer   = (state_q == ST_XFER);
  assign beat     = inXfer && (write_q ? mem_w_ready : mem_r_valid);
  assign lastBeat = beat && ((beatCnt_q + 1'b1) == chunk);

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    beatCnt_d   = beatCnt_q;
    owner_d     = owner_q;
    rrPtr_d     = rrPtr_q;
    gapCnt_d    = gapCnt_q;
    done_d      = '0;
    stray_d     = stray_q | ((mem_r_valid | mem_w_ready) && !inXfer);

    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          owner_d     = grantIdx;
          write_d     = req_write[grantIdx];
          addr_d      = req_addr[grantIdx*ADDR_W +: ADDR_W];
          remaining_d = reqLen;
          gapCnt_d    = '0;
          // An empty burst completes on the spot without touching the controller.
          if (reqLen == '0) begin
            done_d  = grant;
            rrPtr_d = nextPtr(grantIdx);
            state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        beatCnt_d = '0;
        state_d   = ST_XFER;
      end

      ST_XFER: begin
        if (beat) begin
          beatCnt_d = beatCnt_q + 1'b1;
        end
        if (lastBeat) begin
          addr_d      = addr_q + ADDR_W'(chunk);
          remaining_d = remAfter;
          gapCnt_d    = '0;
          if (remAfter == '0) begin
            done_d  = ownerHot;
            rrPtr_d = nextPtr(owner_q);
          end
          if (GAP_CYCLES == 0)
            state_d = (remAfter != '0) ? ST_ISSUE : ST_IDLE;
          else
            state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gapCnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d = (remaining_q != '0) ? ST_ISSUE : ST_IDLE;
        end else begin
          gapCnt_d = gapCnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      beatCnt_q   <= '0;
      owner_q     <= '0;
      rrPtr_q     <= '0;
      gapCnt_q    <= '0;
      done_q      <= '0;
      stray_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beatCnt_q   <= beatCnt_d;
      owner_q     <= owner_d;
      rrPtr_q     <= rrPtr_d;
      gapCnt_q    <= gapCnt_d;
      done_q      <= done_d;
      stray_q     <= stray_d;
    end
  end

  // Everything facing the requesters is gated by state so reset forces it all low.
  assign req_ready       = (state_q == ST_IDLE && rst_n) ? grant : '0;
  assign req_done        = done_q;
  assign rd_data         = (inXfer && !write_q) ? mem_dout : 8'h00;
  assign rd_valid        = (inXfer && !write_q && mem_r_valid) ? ownerHot : '0;
  assign wr_ready        = (inXfer && write_q && mem_w_ready) ? ownerHot : '0;
  assign mem_din         = (inXfer && write_q) ? wr_data[owner_q*8 +: 8] : 8'h00;
  assign mem_start_read  = (state_q == ST_ISSUE) && !write_q;
  assign mem_start_write = (state_q == ST_ISSUE) && write_q;
  assign mem_addr        = (state_q == ST_ISSUE || inXfer) ? addr_q : '0;
  assign mem_count       = (state_q == ST_ISSUE || inXfer) ? chunk : '0;
  assign stray_err       = stray_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a behavioural controller that answers
// every start pulse with mem_count back-to-back beats.
module tb_psram_arbiter;

  localparam int NREQ = 4;
  localparam int GAP  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_write;
  logic [NREQ*23-1:0]  req_addr;
  logic [NREQ*9-1:0]   req_len;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     req_done;
  logic [7:0]          rd_data;
  logic [NREQ-1:0]     rd_valid;
  logic [NREQ*8-1:0]   wr_data;
  logic [NREQ-1:0]     wr_ready;
  logic                mem_start_read;
  logic                mem_start_write;
  logic [8:0]          mem_count;
  logic [22:0]         mem_addr;
  logic [7:0]          mem_dout = 8'h00;
  logic                mem_r_valid;
  logic [7:0]          mem_din;
  logic                mem_w_ready;
  logic                stray_err;

  logic modelRv = 1'b0;
  logic modelWr = 1'b0;
  logic manualRv = 1'b0;
  assign mem_r_valid = modelRv | manualRv;
  assign mem_w_ready = modelWr;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic        wr;
    logic [22:0] addr;
    logic [8:0]  count;
    int          cyc;
  } startRec_t;

  startRec_t starts[$];
  int        beatCycs[$];
  int        rdBeats[NREQ];
  int        wrBeats[NREQ];
  int        doneCnt[NREQ];
  int        bothStarts = 0;
  int        wrDataBad = 0;
  int        rdDataBad = 0;
  int        grantOrder[8];

  psram_arbiter #(
    .NREQ(NREQ),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_len        (req_len),
    .req_ready      (req_ready),
    .req_done       (req_done),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .mem_start_read (mem_start_read),
    .mem_start_write(mem_start_write),
    .mem_count      (mem_count),
    .mem_addr       (mem_addr),
    .mem_dout       (mem_dout),
    .mem_r_valid    (mem_r_valid),
    .mem_din        (mem_din),
    .mem_w_ready    (mem_w_ready),
    .stray_err      (stray_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: a start pulse is followed by mem_count consecutive beats,
  // abandoned as soon as reset is seen.
  always begin : controllerModel
    logic isWr;
    int   n;
    @(negedge clk);
    if (mem_start_read || mem_start_write) begin
      isWr = mem_start_write;
      n    = int'(mem_count);
      @(posedge clk); #1;
      for (int b = 0; b < n; b++) begin
        if (!rst_n) break;
        if (isWr) modelWr = 1'b1;
        else begin
          modelRv  = 1'b1;
          mem_dout = 8'(8'h30 + b);
        end
        @(posedge clk); #1;
      end
      modelRv = 1'b0;
      modelWr = 1'b0;
    end
  end

  // Passive log of everything the DUT does, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_start_read || mem_start_write)
      starts.push_back('{mem_start_write, mem_addr, mem_count, cyc});
    if (mem_start_read && mem_start_write) bothStarts <= bothStarts + 1;
    if ((|rd_valid) || (|wr_ready)) beatCycs.push_back(cyc);
    if ((|rd_valid) && rd_data !== mem_dout) rdDataBad <= rdDataBad + 1;
    for (int p = 0; p < NREQ; p++) begin
      if (rd_valid[p]) rdBeats[p] <= rdBeats[p] + 1;
      if (wr_ready[p]) begin
        wrBeats[p] <= wrBeats[p] + 1;
        if (mem_din !== 8'(8'hA0 + p)) wrDataBad <= wrDataBad + 1;
      end
      if (req_done[p]) doneCnt[p] <= doneCnt[p] + 1;
    end
  end

  initial begin : watchdog
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Raise one request and hold it until the DUT accepts it.
  task automatic applyStimulus(input int port, input logic wr, input logic [22:0] addr,
                               input logic [8:0] len, output int readyCyc);
    bit got;
    got = 1'b0;
    readyCyc = -1;
    @(posedge clk); #1;
    req_valid[port] = 1'b1;
    req_write[port] = wr;
    req_addr[port*23 +: 23] = addr;
    req_len[port*9 +: 9] = len;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (req_ready[port]) begin
        got = 1'b1;
        readyCyc = cyc;
        break;
      end
    end
    checkOutput($sformatf("accept_port%0d", port), 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid[port] = 1'b0;
  endtask

  task automatic waitDone(input int port, output int doneCyc);
    bit got;
    got = 1'b0;
    doneCyc = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (req_done[port]) begin
        got = 1'b1;
        doneCyc = cyc;
        break;
      end
    end
    checkOutput($sformatf("done_port%0d", port), 32'(got), 32'd1);
  endtask

  task automatic collectGrants(input int n, input bit dropGranted);
    int cnt;
    int idx;
    cnt = 0;
    for (int k = 0; k < 600 && cnt < n; k++) begin
      @(negedge clk);
      if (|req_ready) begin
        idx = 0;
        for (int p = 0; p < NREQ; p++) if (req_ready[p]) idx = p;
        grantOrder[cnt] = idx;
        cnt++;
        @(posedge clk); #1;
        if (dropGranted) req_valid[idx] = 1'b0;
        else if (cnt == n) req_valid = '0;
      end
    end
    checkOutput("grant_count", 32'(cnt), 32'(n));
  endtask

  initial begin : stimulus
    int rc, dc, sBase, bBase, d0, s0;
    int expOrder[5];
    int beats;
    bit got;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_len   = '0;
    for (int p = 0; p < NREQ; p++) wr_data[p*8 +: 8] = 8'(8'hA0 + p);

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_done", 32'(req_done), 32'd0);
    checkOutput("rst_starts", {30'd0, mem_start_read, mem_start_write}, 32'd0);
    checkOutput("rst_addr_count", 32'(mem_addr) | 32'(mem_count), 32'd0);
    checkOutput("rst_stray", 32'(stray_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single read
    sBase = starts.size(); bBase = beatCycs.size();
    applyStimulus(0, 1'b0, 23'h000100, 9'd16, rc);
    waitDone(0, dc);
    repeat (4) @(posedge clk);
    checkOutput("rd_nstarts", 32'(starts.size() - sBase), 32'd1);
    checkOutput("rd_start_wr", 32'(starts[sBase].wr), 32'd0);
    checkOutput("rd_start_addr", 32'(starts[sBase].addr), 32'h100);
    checkOutput("rd_start_count", 32'(starts[sBase].count), 32'd16);
    checkOutput("rd_start_latency", 32'(starts[sBase].cyc - rc), 32'd1);
    checkOutput("rd_beats0", 32'(rdBeats[0]), 32'd16);
    checkOutput("rd_beats_other", 32'(rdBeats[1] + rdBeats[2] + rdBeats[3]), 32'd0);
    checkOutput("rd_done_latency", 32'(dc - beatCycs[bBase + 15]), 32'd1);

    // Page split write
    sBase = starts.size(); bBase = beatCycs.size();
    applyStimulus(1, 1'b1, 23'h0003F0, 9'd40, rc);
    waitDone(1, dc);
    repeat (4) @(posedge clk);
    checkOutput("ps_nstarts", 32'(starts.size() - sBase), 32'd2);
    checkOutput("ps_c1_wr", 32'(starts[sBase].wr), 32'd1);
    checkOutput("ps_c1_addr", 32'(starts[sBase].addr), 32'h3F0);
    checkOutput("ps_c1_count", 32'(starts[sBase].count), 32'd16);
    checkOutput("ps_c2_addr", 32'(starts[sBase+1].addr), 32'h400);
    checkOutput("ps_c2_count", 32'(starts[sBase+1].count), 32'd24);
    checkOutput("ps_gap", 32'(starts[sBase+1].cyc - beatCycs[bBase + 15]), 32'(1 + GAP));
    checkOutput("ps_wrbeats1", 32'(wrBeats[1]), 32'd40);
    checkOutput("ps_done1", 32'(doneCnt[1]), 32'd1);

    // Zero length
    sBase = starts.size();
    applyStimulus(2, 1'b0, 23'h000123, 9'd0, rc);
    waitDone(2, dc);
    repeat (5) @(posedge clk);
    checkOutput("zl_done_latency", 32'(dc - rc), 32'd1);
    checkOutput("zl_nstarts", 32'(starts.size() - sBase), 32'd0);

    // Address wrap at the top of the 23-bit space
    sBase = starts.size();
    applyStimulus(3, 1'b0, 23'h7FFFFC, 9'd8, rc);
    waitDone(3, dc);
    repeat (4) @(posedge clk);
    checkOutput("wr_nstarts", 32'(starts.size() - sBase), 32'd2);
    checkOutput("wrap_c1_addr", 32'(starts[sBase].addr), 32'h7FFFFC);
    checkOutput("wrap_c1_count", 32'(starts[sBase].count), 32'd4);
    checkOutput("wrap_c2_addr", 32'(starts[sBase+1].addr), 32'h0);
    checkOutput("wrap_c2_count", 32'(starts[sBase+1].count), 32'd4);
    checkOutput("wrap_beats3", 32'(rdBeats[3]), 32'd8);

    // Round robin with every port requesting continuously
    @(posedge clk); #1;
    for (int p = 0; p < NREQ; p++) begin
      req_write[p] = 1'b0;
      req_addr[p*23 +: 23] = 23'(23'h001000 * (p + 1));
      req_len[p*9 +: 9] = 9'd4;
    end
    req_valid = '1;
    collectGrants(5, 1'b0);
    waitDone(0, dc);
    repeat (4) @(posedge clk);
    expOrder = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("rr_grant%0d", i), 32'(grantOrder[i]), 32'(expOrder[i]));

    // Reset during the 5th beat of a 32-byte read, then a stray beat
    applyStimulus(0, 1'b0, 23'h002000, 9'd32, rc);
    beats = 0; got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rd_valid[0]) begin
        beats++;
        if (beats == 5) begin got = 1'b1; break; end
      end
    end
    checkOutput("mid_reach_beat5", 32'(got), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("mid_rd_data", 32'(rd_data), 32'd0);
    checkOutput("mid_starts", {30'd0, mem_start_read, mem_start_write}, 32'd0);
    checkOutput("mid_addr", 32'(mem_addr), 32'd0);
    checkOutput("mid_count", 32'(mem_count), 32'd0);
    checkOutput("mid_din", 32'(mem_din), 32'd0);
    checkOutput("mid_done_ready", 32'(req_done) | 32'(req_ready), 32'd0);
    d0 = doneCnt[0]; s0 = starts.size();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_nodone", 32'(doneCnt[0] - d0), 32'd0);
    checkOutput("post_rst_nostart", 32'(starts.size() - s0), 32'd0);
    checkOutput("post_rst_stray", 32'(stray_err), 32'd0);
    @(posedge clk); #1;
    manualRv = 1'b1;
    @(negedge clk);
    checkOutput("stray_rd_valid", 32'(rd_valid), 32'd0);
    @(posedge clk); #1;
    manualRv = 1'b0;
    @(negedge clk);
    checkOutput("stray_set", 32'(stray_err), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("stray_sticky", 32'(stray_err), 32'd1);

    // Pointer must be back at 0: ports 0 and 1 together, port 0 first
    @(posedge clk); #1;
    req_len[0 +: 9] = 9'd0;
    req_len[9 +: 9] = 9'd0;
    req_valid = 4'b0011;
    collectGrants(2, 1'b1);
    checkOutput("ptr_rst_first", 32'(grantOrder[0]), 32'd0);
    checkOutput("ptr_rst_second", 32'(grantOrder[1]), 32'd1);
    repeat (5) @(posedge clk);

    checkOutput("no_dual_start", 32'(bothStarts), 32'd0);
    checkOutput("wr_data_route", 32'(wrDataBad), 32'd0);
    checkOutput("rd_data_route", 32'(rdDataBad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
